// File: rtl/alisim_fx_pkg.sv
// Shared fixed-point definitions for the sequence-simulation datapath.
// Words are signed Q7.32; products narrow by saturation so nothing ever wraps.
package alisim_fx_pkg;

    localparam int DATA_W = 40;
    localparam int FRAC_W = 32;
    localparam int ACC_W  = DATA_W + 2;
    localparam int WIDE_W = 2 * DATA_W;

    typedef logic signed [DATA_W-1:0] fx_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [WIDE_W-1:0] fx_wide_t;

    localparam fx_t FX_ONE = fx_t'(1) <<< FRAC_W;
    localparam fx_t FX_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic fx_t fx_sat(input fx_wide_t v);
        fx_wide_t hi;
        fx_wide_t lo;
        hi = fx_wide_t'(FX_MAX);
        lo = fx_wide_t'(FX_MIN);
        if (v > hi)
            return FX_MAX;
        else if (v < lo)
            return FX_MIN;
        else
            return v[DATA_W-1:0];
    endfunction

    // Fraction bits are dropped by flooring shift; the integer part clamps
    // instead of being cut, which is what keeps large rates from wrapping.
    function automatic fx_t fx_mul(input fx_t a, input fx_t b);
        fx_wide_t p;
        p = fx_wide_t'(a) * fx_wide_t'(b);
        p = p >>> FRAC_W;
        return fx_sat(p);
    endfunction

endpackage

// File: rtl/fx_mat4_mul.sv
// Combinational 4x4 fixed-point matrix multiply, row-major flattened operands.
// Results stay at ACC_W so the sum of four saturated products cannot overflow.
module fx_mat4_mul
    import alisim_fx_pkg::*;
(
    input  logic [16*DATA_W-1:0] a,
    input  logic [16*DATA_W-1:0] b,
    output logic [16*ACC_W-1:0]  y
);

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            acc_t sum;

            always_comb begin
                sum = '0;
                for (int k = 0; k < 4; k++) begin
                    sum = sum + acc_t'(fx_mul(a[(4*i+k)*DATA_W +: DATA_W],
                                              b[(4*k+j)*DATA_W +: DATA_W]));
                end
            end

            assign y[(4*i+j)*ACC_W +: ACC_W] = sum;
        end
    end

endmodule

// File: rtl/main_core.sv
// JC69 substitution-matrix engine: P(t) ~= I + Qt + (Qt)^2/2, registered as
// sixteen parallel words in A,C,G,T row-major order.
module main_core
    import alisim_fx_pkg::*;
#(
    parameter fx_t RATE_OFF  = 40'sh0055555555,
    parameter fx_t RATE_DIAG = 40'shFF00000000,
    parameter fx_t BRANCH_T  = 40'sh001999999A
)(
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] matrix_0,
    output logic [DATA_W-1:0] matrix_1,
    output logic [DATA_W-1:0] matrix_2,
    output logic [DATA_W-1:0] matrix_3,
    output logic [DATA_W-1:0] matrix_4,
    output logic [DATA_W-1:0] matrix_5,
    output logic [DATA_W-1:0] matrix_6,
    output logic [DATA_W-1:0] matrix_7,
    output logic [DATA_W-1:0] matrix_8,
    output logic [DATA_W-1:0] matrix_9,
    output logic [DATA_W-1:0] matrix_10,
    output logic [DATA_W-1:0] matrix_11,
    output logic [DATA_W-1:0] matrix_12,
    output logic [DATA_W-1:0] matrix_13,
    output logic [DATA_W-1:0] matrix_14,
    output logic [DATA_W-1:0] matrix_15
);

    logic [16*DATA_W-1:0] m_flat;
    logic [16*ACC_W-1:0]  s_flat;
    fx_t                  p_next [16];
    fx_t                  p_reg  [16];

    fx_mat4_mul u_square (
        .a (m_flat),
        .b (m_flat),
        .y (s_flat)
    );

    // Diagonal entries are those with k = 5*i, i.e. k % 5 == 0 for k < 16.
    for (genvar k = 0; k < 16; k++) begin : g_entry
        localparam fx_t IDENT = (k % 5 == 0) ? FX_ONE : fx_t'(0);
        localparam fx_t RATE  = (k % 5 == 0) ? RATE_DIAG : RATE_OFF;
        fx_wide_t total;

        assign m_flat[k*DATA_W +: DATA_W] = fx_mul(RATE, BRANCH_T);
        assign total = fx_wide_t'(IDENT)
                     + fx_wide_t'(fx_t'(m_flat[k*DATA_W +: DATA_W]))
                     + fx_wide_t'(acc_t'(s_flat[k*ACC_W +: ACC_W]) >>> 1);
        assign p_next[k] = fx_sat(total);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            p_reg <= '{default: '0};
        else
            p_reg <= p_next;
    end

    assign matrix_0  = p_reg[0];
    assign matrix_1  = p_reg[1];
    assign matrix_2  = p_reg[2];
    assign matrix_3  = p_reg[3];
    assign matrix_4  = p_reg[4];
    assign matrix_5  = p_reg[5];
    assign matrix_6  = p_reg[6];
    assign matrix_7  = p_reg[7];
    assign matrix_8  = p_reg[8];
    assign matrix_9  = p_reg[9];
    assign matrix_10 = p_reg[10];
    assign matrix_11 = p_reg[11];
    assign matrix_12 = p_reg[12];
    assign matrix_13 = p_reg[13];
    assign matrix_14 = p_reg[14];
    assign matrix_15 = p_reg[15];

endmodule

// File: tb/tb_main_core.sv
// Bench for main_core: default, zero-branch and saturating instances checked
// against a matrix-level model with randomised reset timing.
module tb_main_core;

    localparam int     N   = 16;
    localparam longint ONE = 64'sd4294967296;
    localparam longint HI  = 64'sh0000007FFFFFFFFF;
    localparam longint LO  = -64'sh0000008000000000;

    localparam logic [39:0] DEF_OFF  = 40'h0055555555;
    localparam logic [39:0] DEF_DIAG = 40'hFF00000000;
    localparam logic [39:0] DEF_T    = 40'h001999999A;
    localparam logic [39:0] BIG      = 40'h7FFFFFFFFF;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [39:0] out_def  [N];
    logic [39:0] out_zero [N];
    logic [39:0] out_sat  [N];
    logic [39:0] exp_def  [N];
    logic [39:0] exp_zero [N];
    logic [39:0] exp_sat  [N];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    main_core dut_def (
        .clk(clk), .reset(reset),
        .matrix_0(out_def[0]),   .matrix_1(out_def[1]),   .matrix_2(out_def[2]),   .matrix_3(out_def[3]),
        .matrix_4(out_def[4]),   .matrix_5(out_def[5]),   .matrix_6(out_def[6]),   .matrix_7(out_def[7]),
        .matrix_8(out_def[8]),   .matrix_9(out_def[9]),   .matrix_10(out_def[10]), .matrix_11(out_def[11]),
        .matrix_12(out_def[12]), .matrix_13(out_def[13]), .matrix_14(out_def[14]), .matrix_15(out_def[15])
    );

    main_core #(.BRANCH_T(40'h0)) dut_zero (
        .clk(clk), .reset(reset),
        .matrix_0(out_zero[0]),   .matrix_1(out_zero[1]),   .matrix_2(out_zero[2]),   .matrix_3(out_zero[3]),
        .matrix_4(out_zero[4]),   .matrix_5(out_zero[5]),   .matrix_6(out_zero[6]),   .matrix_7(out_zero[7]),
        .matrix_8(out_zero[8]),   .matrix_9(out_zero[9]),   .matrix_10(out_zero[10]), .matrix_11(out_zero[11]),
        .matrix_12(out_zero[12]), .matrix_13(out_zero[13]), .matrix_14(out_zero[14]), .matrix_15(out_zero[15])
    );

    main_core #(.RATE_OFF(BIG), .BRANCH_T(BIG)) dut_sat (
        .clk(clk), .reset(reset),
        .matrix_0(out_sat[0]),   .matrix_1(out_sat[1]),   .matrix_2(out_sat[2]),   .matrix_3(out_sat[3]),
        .matrix_4(out_sat[4]),   .matrix_5(out_sat[5]),   .matrix_6(out_sat[6]),   .matrix_7(out_sat[7]),
        .matrix_8(out_sat[8]),   .matrix_9(out_sat[9]),   .matrix_10(out_sat[10]), .matrix_11(out_sat[11]),
        .matrix_12(out_sat[12]), .matrix_13(out_sat[13]), .matrix_14(out_sat[14]), .matrix_15(out_sat[15])
    );

    // Reference model: numbers held as plain 64-bit integers scaled by 2^32.
    function automatic longint sx(input logic [39:0] v);
        logic signed [39:0] s;
        s = v;
        return s;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    function automatic longint ref_mul(input longint a, input longint b);
        logic signed [127:0] wa, wb, p, whi, wlo;
        wa  = a;
        wb  = b;
        whi = HI;
        wlo = LO;
        p   = (wa * wb) >>> 32;
        if (p > whi) return HI;
        if (p < wlo) return LO;
        return longint'(p);
    endfunction

    function automatic logic [16*40-1:0] model_p(input logic [39:0] q_off,
                                                 input logic [39:0] q_diag,
                                                 input logic [39:0] t);
        longint            m [4][4];
        longint            s;
        longint            p;
        logic [16*40-1:0]  r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = ref_mul(sx(i == j ? q_diag : q_off), sx(t));
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += ref_mul(m[i][k], m[k][j]);
                p = clamp((i == j ? ONE : 64'sd0) + m[i][j] + (s >>> 1));
                r[(4*i+j)*40 +: 40] = p[39:0];
            end
        end
        return r;
    endfunction

    function automatic longint absdiff(input logic [39:0] a, input logic [39:0] b);
        longint d;
        d = sx(a) - sx(b);
        return (d < 0) ? -d : d;
    endfunction

    task automatic build_expectations();
        logic [16*40-1:0] v;
        v = model_p(DEF_OFF, DEF_DIAG, DEF_T);
        for (int k = 0; k < N; k++) exp_def[k] = v[k*40 +: 40];
        v = model_p(DEF_OFF, DEF_DIAG, 40'h0);
        for (int k = 0; k < N; k++) exp_zero[k] = v[k*40 +: 40];
        v = model_p(BIG, DEF_DIAG, BIG);
        for (int k = 0; k < N; k++) exp_sat[k] = v[k*40 +: 40];
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (out_def[k] !== 40'h0 || out_zero[k] !== 40'h0 || out_sat[k] !== 40'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_pre_edge k=%0d: got %h/%h/%h expected 0", k, out_def[k], out_zero[k], out_sat[k]);
            end
        end
        repeat (2 + $urandom_range(0, 2)) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (out_def[k] !== 40'h0 || out_zero[k] !== 40'h0 || out_sat[k] !== 40'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_held k=%0d: got %h/%h/%h expected 0", k, out_def[k], out_zero[k], out_sat[k]);
            end
        end
    endtask

    task automatic test_defaults();
        real v;
        @(negedge clk);
        #($urandom_range(1, 4));
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (absdiff(out_def[k], exp_def[k]) > 16) begin
                n_fail++;
                $display("[TB] FAIL default_value k=%0d: got %h expected %h +/-16", k, out_def[k], exp_def[k]);
            end
            v = $itor(sx(out_def[k])) / 4294967296.0;
            n_tests++;
            if ((k % 5 == 0 && (v - 0.906667 > 1.0e-5 || 0.906667 - v > 1.0e-5)) ||
                (k % 5 != 0 && (v - 0.031111 > 1.0e-5 || 0.031111 - v > 1.0e-5))) begin
                n_fail++;
                $display("[TB] FAIL default_real k=%0d: got %f expected %f", k, v, (k % 5 == 0) ? 0.906667 : 0.031111);
            end
        end
        for (int k = 1; k < N; k++) begin
            n_tests++;
            if (k % 5 == 0 && out_def[k] !== out_def[0]) begin
                n_fail++;
                $display("[TB] FAIL diag_equal k=%0d: got %h required %h", k, out_def[k], out_def[0]);
            end else if (k % 5 != 0 && out_def[k] !== out_def[1]) begin
                n_fail++;
                $display("[TB] FAIL offdiag_equal k=%0d: got %h required %h", k, out_def[k], out_def[1]);
            end
        end
    endtask

    task automatic test_row_sums_stable();
        longint sum;
        for (int i = 0; i < 4; i++) begin
            sum = 0;
            for (int j = 0; j < 4; j++) sum += sx(out_def[4*i+j]);
            n_tests++;
            if (sum - ONE > 16 || ONE - sum > 16) begin
                n_fail++;
                $display("[TB] FAIL row_sum row=%0d: got %h expected 0100000000 +/-16", i, sum);
            end
        end
        repeat (10 + $urandom_range(0, 5)) begin
            @(posedge clk);
            #($urandom_range(1, 8));
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (out_def[k] !== exp_def[k]) begin
                    n_fail++;
                    $display("[TB] FAIL stable k=%0d: got %h expected %h", k, out_def[k], exp_def[k]);
                end
            end
        end
    endtask

    task automatic test_zero_branch();
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (out_zero[k] !== exp_zero[k] || out_zero[k] !== ((k % 5 == 0) ? 40'h0100000000 : 40'h0)) begin
                n_fail++;
                $display("[TB] FAIL zero_branch k=%0d: got %h expected %h", k, out_zero[k], exp_zero[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #($urandom_range(1, 8));
        reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (out_def[k] !== 40'h0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_clear k=%0d: got %h expected 0", k, out_def[k]);
            end
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_def[0] !== 40'h0 || out_def[1] !== 40'h0) begin
            n_fail++;
            $display("[TB] FAIL release_before_edge: got %h/%h expected 0", out_def[0], out_def[1]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (out_def[k] !== exp_def[k]) begin
                n_fail++;
                $display("[TB] FAIL reload k=%0d: got %h expected %h", k, out_def[k], exp_def[k]);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (out_sat[k] !== exp_sat[k]) begin
                n_fail++;
                $display("[TB] FAIL sat_value k=%0d: got %h expected %h", k, out_sat[k], exp_sat[k]);
            end
            n_tests++;
            if (out_sat[k][39] !== 1'b0 || absdiff(out_sat[k], BIG) > 16) begin
                n_fail++;
                $display("[TB] FAIL sat_limit k=%0d: got %h expected near %h", k, out_sat[k], BIG);
            end
            if (k % 5 == 0) begin
                n_tests++;
                if (out_sat[k] !== BIG) begin
                    n_fail++;
                    $display("[TB] FAIL sat_diag k=%0d: got %h expected %h", k, out_sat[k], BIG);
                end
            end
        end
    endtask

    initial begin
        build_expectations();
        test_reset();
        test_defaults();
        test_row_sums_stable();
        test_zero_branch();
        test_saturation();
        test_mid_reset();
        test_zero_branch();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
